cca_nav_hyst: RTL and testbench

CCA_NAV_HYST -- requirements
Module: cca_nav_hyst

---
 rtl/cca_nav_hyst.sv | 197 +++++++++++++++++++
 tb/tb_cca_nav_hyst.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cca_nav_hyst.sv
// cca_nav_hyst: clear-channel assessment with per-channel energy-detect hysteresis,
// a post-decode hold window, and an optional NAV timer.
//
// Optional feature: define CCA_NAV_EN to build the NAV counter. Without it the NAV
// inputs are ignored and nav_remaining is tied to zero.
//
// Ports:
//   clk, rstn                     clock and asynchronous active-low reset
//   rssi_half_db                  packed signed RSSI per channel, channel 0 in the LSBs
//   rssi_half_db_th, hyst_half_db busy threshold (signed) and clear hysteresis (unsigned)
//   rx_ht_aggr, rx_ht_aggr_last   aggregate framing qualifiers for fcs_in_strobe
//   demod_is_ongoing              receiver is demodulating
//   tx_rf_is_ongoing, cts_toself_rf_is_ongoing, ack_cts_is_ongoing  local TX activity
//   fcs_in_strobe                 frame check sequence received
//   wait_after_decode_top         hold length in units of COUNT_SCALE cycles
//   us_tick, nav_load, nav_clear, nav_value  NAV control
//   ch_idle                       registered channel-idle indication
//   ed_busy                       per-channel energy-detect busy
//   nav_remaining                 NAV counter in microseconds
//   idle_run_count                consecutive cycles of ch_idle, saturating
//   cca_state                     0 idle, 1 busy, 2 hold
module cca_nav_hyst #(
   parameter int unsigned RSSI_HALF_DB_WIDTH = 11,
   parameter int unsigned NUM_CH             = 2,
   parameter int unsigned COUNT_SCALE        = 5,
   parameter int unsigned NAV_WIDTH          = 16
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic [NUM_CH*RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
   input  logic [RSSI_HALF_DB_WIDTH-1:0]        rssi_half_db_th,
   input  logic [RSSI_HALF_DB_WIDTH-1:0]        hyst_half_db,
   input  logic                                 rx_ht_aggr,
   input  logic                                 rx_ht_aggr_last,
   input  logic                                 demod_is_ongoing,
   input  logic                                 tx_rf_is_ongoing,
   input  logic                                 cts_toself_rf_is_ongoing,
   input  logic                                 ack_cts_is_ongoing,
   input  logic                                 fcs_in_strobe,
   input  logic                                 us_tick,
   input  logic                                 nav_load,
   input  logic                                 nav_clear,
   input  logic [7:0]                           wait_after_decode_top,
   input  logic [NAV_WIDTH-1:0]                 nav_value,
   output logic                                 ch_idle,
   output logic [NUM_CH-1:0]                    ed_busy,
   output logic [NAV_WIDTH-1:0]                 nav_remaining,
   output logic [15:0]                          idle_run_count,
   output logic [1:0]                           cca_state
);

   localparam int unsigned W      = RSSI_HALF_DB_WIDTH;
   // Two guard bits so th - hyst cannot wrap even for the most negative threshold
   // combined with the largest hysteresis.
   localparam int unsigned CW     = W + 2;
   localparam int unsigned HOLD_W = 12;
   localparam int unsigned PROD_W = 40;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StHold = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [HOLD_W-1:0]   hold_top_q, hold_top_d;
   logic [NUM_CH-1:0]   ed_busy_q, ed_busy_d;
   logic                ch_idle_q, ch_idle_d;
   logic [15:0]         run_q, run_d;
   logic                phy_busy, eof, nav_busy;

   // Energy detect with hysteresis
   logic signed [CW-1:0] th_ext, clr_lvl;
   logic signed [CW-1:0] rssi_ext [NUM_CH];

   assign th_ext  = {{2{rssi_half_db_th[W-1]}}, rssi_half_db_th};
   assign clr_lvl = th_ext - $signed({2'b00, hyst_half_db});

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign rssi_ext[g] = {{2{rssi_half_db[g*W+W-1]}}, rssi_half_db[g*W +: W]};
   end

   always_comb begin
      ed_busy_d = ed_busy_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rssi_ext[i] > th_ext) begin
            ed_busy_d[i] = 1'b1;
         end else if (rssi_ext[i] <= clr_lvl) begin
            ed_busy_d[i] = 1'b0;
         end
      end
   end

   assign phy_busy = (|ed_busy_q) | demod_is_ongoing;
   assign eof      = fcs_in_strobe & (~rx_ht_aggr | rx_ht_aggr_last);

   // Hold length, saturated into the hold counter width
   logic [PROD_W-1:0] hold_prod;
   assign hold_prod  = PROD_W'(wait_after_decode_top) * PROD_W'(COUNT_SCALE);
   assign hold_top_d = (hold_prod > PROD_W'({HOLD_W{1'b1}})) ? {HOLD_W{1'b1}}
                                                             : hold_prod[HOLD_W-1:0];

   // State machine; an end-of-frame always (re)starts the hold window
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      if (eof && (hold_top_q != '0)) begin
         state_d    = StHold;
         hold_cnt_d = '0;
      end else begin
         case (state_q)
            StIdle: if (phy_busy) state_d = StBusy;
            StBusy: if (!phy_busy) state_d = StIdle;
            StHold: begin
               // hold_cnt counts cycles already spent in HOLD, leave after hold_top of them
               if ((32'(hold_cnt_q) + 32'd1) >= 32'(hold_top_q)) begin
                  state_d    = phy_busy ? StBusy : StIdle;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // NAV timer
`ifdef CCA_NAV_EN
   logic [NAV_WIDTH-1:0] nav_q, nav_d;

   always_comb begin
      nav_d = nav_q;
      if (nav_clear) begin
         nav_d = '0;
      end else if (nav_load) begin
         nav_d = (nav_value > nav_q) ? nav_value : nav_q;
      end else if (us_tick && (nav_q != '0)) begin
         nav_d = nav_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         nav_q <= '0;
      end else begin
         nav_q <= nav_d;
      end
   end

   assign nav_remaining = nav_q;
   assign nav_busy      = (nav_q != '0);
`else
   logic nav_unused;
   assign nav_unused    = ^{us_tick, nav_load, nav_clear, nav_value};
   assign nav_remaining = '0;
   assign nav_busy      = 1'b0;
`endif

   // Channel idle uses the current state, so it trails state changes by one cycle
   always_comb begin
      ch_idle_d = ((state_q == StIdle) || (state_q == StHold)) && !nav_busy &&
                  !tx_rf_is_ongoing && !cts_toself_rf_is_ongoing && !ack_cts_is_ongoing;
      if (!ch_idle_q) begin
         run_d = '0;
      end else if (run_q == 16'hFFFF) begin
         run_d = run_q;
      end else begin
         run_d = run_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         hold_cnt_q <= '0;
         hold_top_q <= '0;
         ed_busy_q  <= '0;
         ch_idle_q  <= 1'b0;
         run_q      <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         hold_top_q <= hold_top_d;
         ed_busy_q  <= ed_busy_d;
         ch_idle_q  <= ch_idle_d;
         run_q      <= run_d;
      end
   end

   assign ed_busy        = ed_busy_q;
   assign ch_idle        = ch_idle_q;
   assign idle_run_count = run_q;
   assign cca_state      = state_q;

endmodule

// File: tb/tb_cca_nav_hyst.sv
// Testbench for cca_nav_hyst: directed scenarios plus randomized traffic. A reference
// model predicts every cycle's outputs into a queue; a monitor compares them.
module tb_cca_nav_hyst;

   localparam int W     = 11;
   localparam int NCH   = 2;
   localparam int NW    = 16;
   localparam int SCALE = 5;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [NCH*W-1:0]  rssi_half_db = '0;
   logic [W-1:0]      rssi_half_db_th = '0;
   logic [W-1:0]      hyst_half_db = '0;
   logic              rx_ht_aggr = 1'b0, rx_ht_aggr_last = 1'b0, demod_is_ongoing = 1'b0;
   logic              tx_rf_is_ongoing = 1'b0, cts_toself_rf_is_ongoing = 1'b0;
   logic              ack_cts_is_ongoing = 1'b0, fcs_in_strobe = 1'b0;
   logic              us_tick = 1'b0, nav_load = 1'b0, nav_clear = 1'b0;
   logic [7:0]        wait_after_decode_top = 8'd2;
   logic [NW-1:0]     nav_value = '0;
   logic              ch_idle;
   logic [NCH-1:0]    ed_busy;
   logic [NW-1:0]     nav_remaining;
   logic [15:0]       idle_run_count;
   logic [1:0]        cca_state;

   cca_nav_hyst dut (
      .clk                      (clk),
      .rstn                     (rstn),
      .rssi_half_db             (rssi_half_db),
      .rssi_half_db_th          (rssi_half_db_th),
      .hyst_half_db             (hyst_half_db),
      .rx_ht_aggr               (rx_ht_aggr),
      .rx_ht_aggr_last          (rx_ht_aggr_last),
      .demod_is_ongoing         (demod_is_ongoing),
      .tx_rf_is_ongoing         (tx_rf_is_ongoing),
      .cts_toself_rf_is_ongoing (cts_toself_rf_is_ongoing),
      .ack_cts_is_ongoing       (ack_cts_is_ongoing),
      .fcs_in_strobe            (fcs_in_strobe),
      .us_tick                  (us_tick),
      .nav_load                 (nav_load),
      .nav_clear                (nav_clear),
      .wait_after_decode_top    (wait_after_decode_top),
      .nav_value                (nav_value),
      .ch_idle                  (ch_idle),
      .ed_busy                  (ed_busy),
      .nav_remaining            (nav_remaining),
      .idle_run_count           (idle_run_count),
      .cca_state                (cca_state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic           idle;
      logic [NCH-1:0] ed;
      logic [NW-1:0]  nav;
      logic [15:0]    run;
      logic [1:0]     st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Stimulus values in plain integers
   int rssi_v [NCH];
   int th_v   = -62;
   int hyst_v = 4;

   // Reference model state: mode 0 idle, 1 busy, 2 hold; hold_left = HOLD cycles still to go
   bit m_ed [NCH];
   int m_mode, m_left, m_htop, m_nav, m_run;
   bit m_idle;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
      end
   endtask

   // Monitor: compare the prediction for each clock edge just after it
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_ch_idle", int'(ch_idle), int'(e.idle));
            chk("sb_ed_busy", int'(ed_busy), int'(e.ed));
            chk("sb_nav_remaining", int'(nav_remaining), int'(e.nav));
            chk("sb_idle_run_count", int'(idle_run_count), int'(e.run));
            chk("sb_cca_state", int'(cca_state), int'(e.st));
         end
      end
   end

   // Apply inputs, predict the next edge, push the prediction, advance to next negedge
   task automatic cycle();
      exp_t e;
      bit   phy, eof, n_idle;
      int   n_run, n_mode, n_left, n_htop, n_nav;
      bit   n_ed [NCH];
      for (int i = 0; i < NCH; i++) rssi_half_db[i*W +: W] = W'(rssi_v[i]);
      rssi_half_db_th = W'(th_v);
      hyst_half_db    = W'(hyst_v);
      if (!rstn) begin
         for (int i = 0; i < NCH; i++) m_ed[i] = 1'b0;
         m_mode = 0; m_left = 0; m_htop = 0; m_nav = 0; m_run = 0; m_idle = 1'b0;
      end else begin
         phy = demod_is_ongoing;
         for (int i = 0; i < NCH; i++) phy = phy | m_ed[i];
         eof = fcs_in_strobe && (!rx_ht_aggr || rx_ht_aggr_last);
         for (int i = 0; i < NCH; i++) begin
            if (rssi_v[i] > th_v)                n_ed[i] = 1'b1;
            else if (rssi_v[i] <= th_v - hyst_v) n_ed[i] = 1'b0;
            else                                 n_ed[i] = m_ed[i];
         end
         n_idle = (m_mode != 1) && (m_nav == 0) && !tx_rf_is_ongoing &&
                  !cts_toself_rf_is_ongoing && !ack_cts_is_ongoing;
         n_run  = m_idle ? ((m_run >= 65535) ? 65535 : m_run + 1) : 0;
         n_mode = m_mode;
         n_left = m_left;
         if (eof && m_htop > 0) begin
            n_mode = 2;
            n_left = m_htop;
         end else if (m_mode == 2) begin
            if (m_left <= 1) n_mode = phy ? 1 : 0;
            else             n_left = m_left - 1;
         end else begin
            n_mode = phy ? 1 : 0;
         end
         n_htop = int'(wait_after_decode_top) * SCALE;
         if (n_htop > 4095) n_htop = 4095;
         n_nav = m_nav;
`ifdef CCA_NAV_EN
         if (nav_clear)                 n_nav = 0;
         else if (nav_load)             n_nav = (int'(nav_value) > m_nav) ? int'(nav_value) : m_nav;
         else if (us_tick && m_nav > 0) n_nav = m_nav - 1;
`endif
         for (int i = 0; i < NCH; i++) m_ed[i] = n_ed[i];
         m_mode = n_mode; m_left = n_left; m_htop = n_htop; m_nav = n_nav;
         m_run = n_run; m_idle = n_idle;
      end
      e.idle = m_idle;
      for (int i = 0; i < NCH; i++) e.ed[i] = m_ed[i];
      e.nav = NW'(m_nav);
      e.run = 16'(m_run);
      e.st  = 2'(m_mode);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic strobe();
      fcs_in_strobe = 1'b1;
      cycle();
      fcs_in_strobe = 1'b0;
   endtask

   // Observe n cycles; count cycles in HOLD and cycles with ch_idle high
   task automatic observe(input int n, output int n_hold, output int n_idl);
      n_hold = 0;
      n_idl  = 0;
      for (int k = 0; k < n; k++) begin
         if (cca_state == 2'd2) n_hold++;
         if (ch_idle) n_idl++;
         cycle();
      end
   endtask

   initial begin
      int nh, ni, exp_nav;
      for (int i = 0; i < NCH; i++) rssi_v[i] = -100;
      cycles(3);
      chk("reset_ch_idle", int'(ch_idle), 0);
      chk("reset_state", int'(cca_state), 0);
      chk("reset_run", int'(idle_run_count), 0);
      rstn = 1'b1;
      cycles(3);
      chk("idle_after_reset", int'(ch_idle), 1);

      // Hysteresis: busy above -62, stays busy at -64, clears at -66
      rssi_v[0] = -60; cycles(3);
      chk("hyst_busy_ed", int'(ed_busy[0]), 1);
      chk("hyst_busy_idle", int'(ch_idle), 0);
      rssi_v[0] = -64; cycles(3);
      chk("hyst_band_ed", int'(ed_busy[0]), 1);
      rssi_v[0] = -66; cycles(3);
      chk("hyst_clear_ed", int'(ed_busy[0]), 0);
      chk("hyst_clear_idle", int'(ch_idle), 1);

      // Clear level must not wrap at the extreme threshold/hysteresis corner
      th_v = -1024; hyst_v = 2047; rssi_v[0] = 1023; cycles(2);
      rssi_v[0] = -1024; cycles(3);
      chk("clr_no_wrap", int'(ed_busy[0]), 1);
      th_v = -62; hyst_v = 4; rssi_v[0] = -100; cycles(3);

      // Post-decode hold: 2 * 5 = 10 cycles, then back to BUSY
      demod_is_ongoing = 1'b1; cycles(3);
      strobe();
      observe(30, nh, ni);
      chk("hold_len", nh, 10);
      chk("hold_idle_len", ni, 10);
      chk("hold_exit_busy", int'(cca_state), 1);

      // Aggregate qualifiers
      rx_ht_aggr = 1'b1; rx_ht_aggr_last = 1'b0;
      strobe();
      observe(15, nh, ni);
      chk("aggr_mid_no_hold", nh, 0);
      rx_ht_aggr_last = 1'b1;
      strobe();
      observe(15, nh, ni);
      chk("aggr_last_hold", nh, 10);
      rx_ht_aggr = 1'b0; rx_ht_aggr_last = 1'b0;

      // TX pulse during HOLD
      strobe(); cycles(3);
      tx_rf_is_ongoing = 1'b1; cycle(); tx_rf_is_ongoing = 1'b0;
      chk("tx_pulse_idle", int'(ch_idle), 0);
      chk("tx_pulse_state", int'(cca_state), 2);
      cycle();
      chk("tx_pulse_run", int'(idle_run_count), 0);
      chk("tx_pulse_hold_cont", int'(cca_state), 2);
      cycles(10);
      demod_is_ongoing = 1'b0; cycles(3);

      // NAV sequence
      nav_load = 1'b1; nav_value = 16'd100; cycle(); nav_load = 1'b0;
      us_tick = 1'b1; cycles(30); us_tick = 1'b0;
      nav_load = 1'b1; nav_value = 16'd50; cycle(); nav_load = 1'b0;
`ifdef CCA_NAV_EN
      exp_nav = 70;
`else
      exp_nav = 0;
`endif
      chk("nav_keep_max", int'(nav_remaining), exp_nav);
      nav_load = 1'b1; nav_value = 16'd90; us_tick = 1'b1; cycle();
      nav_load = 1'b0; us_tick = 1'b0;
`ifdef CCA_NAV_EN
      exp_nav = 90;
`endif
      chk("nav_load_larger", int'(nav_remaining), exp_nav);
      nav_clear = 1'b1; nav_load = 1'b1; cycle(); nav_clear = 1'b0; nav_load = 1'b0;
      chk("nav_clear", int'(nav_remaining), 0);
      cycles(2);
      chk("nav_clear_idle", int'(ch_idle), 1);

      // Reset during HOLD with NAV loaded
      demod_is_ongoing = 1'b1; cycles(2);
      nav_load = 1'b1; nav_value = 16'd40; cycle(); nav_load = 1'b0;
      strobe(); cycles(3);
      rstn = 1'b0;
      #1;
      chk("arst_ch_idle", int'(ch_idle), 0);
      chk("arst_state", int'(cca_state), 0);
      chk("arst_nav", int'(nav_remaining), 0);
      chk("arst_ed", int'(ed_busy), 0);
      chk("arst_run", int'(idle_run_count), 0);
      demod_is_ongoing = 1'b0;
      cycles(2);
      rstn = 1'b1;
      cycles(2);
      chk("post_rst_state", int'(cca_state), 0);
      chk("post_rst_nav", int'(nav_remaining), 0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 599) == 0) begin
            rstn = 1'b0;
            wait_after_decode_top = 8'($urandom_range(0, 2));
            th_v = -40 - int'($urandom_range(0, 60));
            hyst_v = int'($urandom_range(0, 8));
            cycles(2);
            rstn = 1'b1;
         end
         for (int i = 0; i < NCH; i++)
            if ($urandom_range(0, 3) == 0) rssi_v[i] = th_v + int'($urandom_range(0, 24)) - 12;
         demod_is_ongoing         = ($urandom_range(0, 7) == 0);
         fcs_in_strobe            = ($urandom_range(0, 15) == 0);
         rx_ht_aggr               = 1'($urandom_range(0, 1));
         rx_ht_aggr_last          = 1'($urandom_range(0, 1));
         tx_rf_is_ongoing         = ($urandom_range(0, 19) == 0);
         cts_toself_rf_is_ongoing = ($urandom_range(0, 29) == 0);
         ack_cts_is_ongoing       = ($urandom_range(0, 29) == 0);
         us_tick                  = 1'($urandom_range(0, 1));
         nav_load                 = ($urandom_range(0, 29) == 0);
         nav_value                = NW'($urandom_range(0, 200));
         nav_clear                = ($urandom_range(0, 199) == 0);
         cycle();
      end
      fcs_in_strobe = 1'b0;
      cycles(2);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
